// File: rtl/axi_line_fetch_if.sv
// AXI read-channel subset (AR + R) used by the line fetcher.
interface axi_read_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rlast;
  logic                  rready;

  modport master (
    output araddr, arlen, arvalid, rready,
    input  arready, rdata, rresp, rvalid, rlast
  );

  modport slave (
    input  araddr, arlen, arvalid, rready,
    output arready, rdata, rresp, rvalid, rlast
  );
endinterface

// File: rtl/axi_line_fetch.sv
// Fetches one aligned cache line as a single AXI INCR burst and returns it whole.
// Optional macro FETCH_CRITICAL_WORD_EN adds a one-cycle early pulse carrying the requested word.
module axi_line_fetch #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [LINE_WORDS*32-1:0] resp_data,
  output logic                     resp_err,
  output logic                     crit_valid,
  output logic [31:0]              crit_data,
  axi_read_if.master               axi_if
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS * 4);
  localparam int unsigned IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [31:0]           words_q [LINE_WORDS];
  logic [CNT_W-1:0]      beat_cnt_q;
  logic                  err_q;
  logic                  arvalid;
  logic                  rready;
  logic [7:0]            arlen;
  logic                  accept;
  logic                  beat;
  logic                  in_range;

  assign accept   = req_valid && (state_q == IDLE);
  assign beat     = (state_q == R) && axi_if.rvalid;
  assign in_range = beat_cnt_q < CNT_W'(LINE_WORDS);

  assign axi_if.araddr  = araddr_q;
  assign axi_if.arlen   = arlen;
  assign axi_if.arvalid = arvalid;
  assign axi_if.rready  = rready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake decode
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    arlen      = 8'd0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = AR;
      end
      AR: begin
        arvalid = 1'b1;
        arlen   = 8'(LINE_WORDS - 1);
        if (axi_if.arready) state_d = R;
      end
      R: begin
        rready = 1'b1;
        arlen  = 8'(LINE_WORDS - 1);
        if (axi_if.rvalid && axi_if.rlast) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, beat capture and sticky error tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      for (int k = 0; k < int'(LINE_WORDS); k++) words_q[k] <= '0;
    end else if (accept) begin
      araddr_q   <= {req_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      for (int k = 0; k < int'(LINE_WORDS); k++) words_q[k] <= '0;
    end else if (beat) begin
      if (in_range) begin
        words_q[beat_cnt_q[IDX_W-1:0]] <= axi_if.rdata;
        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
        if (axi_if.rresp != 2'b00) err_q <= 1'b1;
        if (axi_if.rlast && (beat_cnt_q != CNT_W'(LINE_WORDS - 1))) err_q <= 1'b1;
      end else begin
        err_q <= 1'b1;
      end
    end
  end

  // Pack the line buffer onto the response bus
  always_comb begin
    resp_data = '0;
    for (int k = 0; k < int'(LINE_WORDS); k++) resp_data[k*32 +: 32] = words_q[k];
  end

`ifdef FETCH_CRITICAL_WORD_EN
  logic [IDX_W-1:0] crit_idx_q;
  logic             crit_valid_q;
  logic [31:0]      crit_data_q;

  // Pulse once when the beat at the requested word index lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crit_idx_q   <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      crit_valid_q <= 1'b0;
      if (accept) crit_idx_q <= req_addr[2 +: IDX_W];
      if (beat && in_range && (beat_cnt_q[IDX_W-1:0] == crit_idx_q)) begin
        crit_valid_q <= 1'b1;
        crit_data_q  <= axi_if.rdata;
      end
    end
  end

  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
`else
  assign crit_valid = 1'b0;
  assign crit_data  = 32'd0;
`endif

endmodule

// File: tb/tb_axi_line_fetch.sv
// Directed bench for axi_line_fetch: the bench plays the AXI responder, whose word at byte 4*i holds i.
module tb_axi_line_fetch;

  localparam int unsigned LW = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = LW * 32;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic          crit_valid;
  logic [31:0]   crit_data;

  int vecs;
  int errs;

  axi_read_if #(.ADDR_WIDTH(AW)) axi_if ();

  axi_line_fetch #(.LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .crit_valid (crit_valid),
    .crit_data  (crit_data),
    .axi_if     (axi_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request at the current negedge; next negedge the AR phase is visible.
  task automatic do_req(input logic [AW-1:0] addr, input logic [AW-1:0] exp_base);
    req_valid = 1'b1;
    req_addr  = addr;
    check("req_ready_idle", DW'(req_ready), DW'(1));
    @(negedge clk);
    req_valid = 1'b0;
    check("arvalid_next", DW'(axi_if.arvalid), DW'(1));
    check("araddr", DW'(axi_if.araddr), DW'(exp_base));
    check("arlen", DW'(axi_if.arlen), DW'(LW - 1));
    check("req_ready_busy", DW'(req_ready), DW'(0));
  endtask

  task automatic do_ar();
    axi_if.arready = 1'b1;
    @(negedge clk);
    axi_if.arready = 1'b0;
    check("arvalid_drop", DW'(axi_if.arvalid), DW'(0));
    check("rready_r", DW'(axi_if.rready), DW'(1));
    check("arlen_hold_r", DW'(axi_if.arlen), DW'(LW - 1));
  endtask

  // Drive n beats, then check the response presented one cycle after the last beat.
  task automatic do_beats(input int base_word, input int n, input int err_beat, input int last_beat,
                          input int crit_idx, input int stored, input logic exp_err);
    logic [DW-1:0] exp;
    int            pulses;
    logic [31:0]   cdata;
    pulses = 0;
    cdata  = '0;
    exp    = '0;
    for (int k = 0; k < int'(LW); k++)
      if (k < stored) exp[k*32 +: 32] = 32'(base_word + k);
    for (int b = 0; b < n; b++) begin
      axi_if.rvalid = 1'b1;
      axi_if.rdata  = 32'(base_word + b);
      axi_if.rresp  = (b == err_beat) ? 2'b10 : 2'b00;
      axi_if.rlast  = (b == last_beat);
      @(negedge clk);
      if (crit_valid) begin
        pulses++;
        cdata = crit_data;
      end
    end
    axi_if.rvalid = 1'b0;
    axi_if.rlast  = 1'b0;
    axi_if.rresp  = 2'b00;
    check("resp_valid", DW'(resp_valid), DW'(1));
    check("resp_err", DW'(resp_err), DW'(exp_err));
    check("resp_data", resp_data, exp);
    check("rready_resp", DW'(axi_if.rready), DW'(0));
`ifdef FETCH_CRITICAL_WORD_EN
    check("crit_pulses", DW'(pulses), DW'(1));
    check("crit_data", DW'(cdata), DW'(base_word + crit_idx));
`else
    check("crit_pulses", DW'(pulses), DW'(0));
    check("crit_data_tied", DW'(crit_data), DW'(0));
`endif
  endtask

  // Hold resp_ready low for hold cycles, then release; optionally offer a request meanwhile.
  task automatic finish_resp(input int hold, input logic offer);
    logic [DW-1:0] snap;
    logic          err_snap;
    snap     = resp_data;
    err_snap = resp_err;
    if (offer) begin
      req_valid = 1'b1;
      req_addr  = 32'h300;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", DW'(resp_valid), DW'(1));
      check("hold_data", resp_data, snap);
      check("hold_err", DW'(resp_err), DW'(err_snap));
      check("hold_req_ready", DW'(req_ready), DW'(0));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_drop", DW'(resp_valid), DW'(0));
    check("back_idle", DW'(req_ready), DW'(1));
    check("no_same_cycle_req", DW'(axi_if.arvalid), DW'(0));
    req_valid = 1'b0;
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    resp_ready = 1'b0;
    axi_if.arready = 1'b0;
    axi_if.rvalid = 1'b0;
    axi_if.rdata = '0;
    axi_if.rresp = 2'b00;
    axi_if.rlast = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_arvalid", DW'(axi_if.arvalid), DW'(0));
    check("rst_rready", DW'(axi_if.rready), DW'(0));
    check("rst_resp_valid", DW'(resp_valid), DW'(0));
    check("rst_araddr", DW'(axi_if.araddr), DW'(0));
    check("rst_arlen", DW'(axi_if.arlen), DW'(0));
    check("rst_resp_data", resp_data, DW'(0));
    check("rst_crit_valid", DW'(crit_valid), DW'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Plain fetch, critical word 1, response held for 10 cycles
    do_req(32'h104, 32'h100);
    do_ar();
    do_beats(32'h40, 8, -1, 7, 1, 8, 1'b0);
    finish_resp(10, 1'b1);

    // SLVERR on beat 3: data still stored, error reported
    do_req(32'h120, 32'h120);
    do_ar();
    do_beats(32'h48, 8, 3, 7, 0, 8, 1'b1);
    finish_resp(1, 1'b0);

    // Short burst: rlast on beat 5, also the critical word
    do_req(32'h154, 32'h140);
    do_ar();
    do_beats(32'h50, 6, -1, 5, 5, 6, 1'b1);
    finish_resp(0, 1'b0);

    // Over-long burst: beats 8 and 9 discarded
    do_req(32'h160, 32'h160);
    do_ar();
    do_beats(32'h58, 10, -1, 9, 0, 8, 1'b1);
    finish_resp(0, 1'b0);

    // Reset asserted during beat 4 abandons the fetch
    do_req(32'h180, 32'h180);
    do_ar();
    for (int b = 0; b < 5; b++) begin
      axi_if.rvalid = 1'b1;
      axi_if.rdata  = 32'(32'h60 + b);
      axi_if.rresp  = 2'b00;
      axi_if.rlast  = 1'b0;
      if (b < 4) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rready", DW'(axi_if.rready), DW'(0));
    check("mid_rst_arlen", DW'(axi_if.arlen), DW'(0));
    check("mid_rst_araddr", DW'(axi_if.araddr), DW'(0));
    check("mid_rst_data", resp_data, DW'(0));
    check("mid_rst_req_ready", DW'(req_ready), DW'(1));
    axi_if.rvalid = 1'b0;
    @(negedge clk);
    check("mid_rst_no_resp", DW'(resp_valid), DW'(0));
    rst_n = 1'b1;
    do_req(32'h200, 32'h200);
    do_ar();
    do_beats(32'h80, 8, -1, 7, 0, 8, 1'b0);
    finish_resp(2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
